// File: rtl/frame_reader.sv
// rtl/frame_reader.sv - prefetching frame-buffer reader feeding a pixel stream
//
// Fetches RAM words ahead of the display into a small FIFO and slices each
// word into PPW pixels, least-significant pixel first.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   frame_start  one-cycle pulse, restart at frame word 0
//   pixel_req    display consumes one pixel this cycle
//   visible      display is in the active area
//   ram_addr     RAM word address (AW bits)
//   ram_rd       read strobe, one word per asserted cycle
//   ram_data     read data, valid RD_LATENCY cycles after ram_rd
//   pixel        registered pixel (PIX_BITS bits)
//   pixel_valid  one cycle per serviced pixel_req
//   underflow    sticky, pixel requested while the FIFO was empty
module frame_reader #(
  parameter int RAM_WIDTH   = 32,
  parameter int PIX_BITS    = 8,
  parameter int FRAME_WORDS = 172800,
  parameter int RD_LATENCY  = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int AW = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 frame_start,
  input  logic                 pixel_req,
  input  logic                 visible,
  output logic [AW-1:0]        ram_addr,
  output logic                 ram_rd,
  input  logic [RAM_WIDTH-1:0] ram_data,
  output logic [PIX_BITS-1:0]  pixel,
  output logic                 pixel_valid,
  output logic                 underflow
);

  localparam int PPW = RAM_WIDTH / PIX_BITS;
  localparam int KW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int LW  = $clog2(RD_LATENCY + 1);
  localparam int SW  = ((CW > LW) ? CW : LW) + 1;

  typedef enum logic [1:0] {IDLE, FILL, STREAM} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [RD_LATENCY-1:0] vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [KW-1:0]         k_q, k_d;
  logic [PIX_BITS-1:0]   pixel_q, pixel_d;
  logic                  pixel_valid_q, pixel_valid_d;
  logic                  underflow_q, underflow_d;

  logic [RAM_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [RAM_WIDTH-1:0]  head_word;
  logic [LW-1:0]         inflight;
  logic [SW-1:0]         occ_total;
  logic                  rd_issue;
  logic                  fifo_wr;
  logic                  fifo_pop;

  // Reads still travelling through the RAM pipeline count against FIFO
  // space so that every issued read is guaranteed a slot when it lands.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + LW'(vld_q[i]);
    end
  end

  assign occ_total = SW'(count_q) + SW'(inflight);
  // A read issued in a frame_start cycle would be discarded anyway, so it is
  // suppressed to keep the restart address at word 0.
  assign rd_issue  = !rst && !frame_start && (state_q != IDLE) &&
                     (occ_total < SW'(FIFO_DEPTH));
  // Data landing in a frame_start or reset cycle belongs to the old frame.
  assign fifo_wr   = vld_q[RD_LATENCY-1] && !frame_start && !rst;
  assign head_word = fifo_mem[rd_ptr_q];

  assign ram_rd      = rd_issue;
  assign ram_addr    = addr_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign underflow   = underflow_q;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    vld_d         = '0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    k_d           = k_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    underflow_d   = underflow_q;
    fifo_pop      = 1'b0;

    // Pixel service; frame_start, IDLE and blanking all emit a zero pixel.
    if (pixel_req) begin
      pixel_valid_d = 1'b1;
      pixel_d       = '0;
      if (!frame_start && (state_q != IDLE) && visible) begin
        if (count_q == '0) begin
          underflow_d = 1'b1;
        end else begin
          pixel_d = head_word[int'(k_q)*PIX_BITS +: PIX_BITS];
          if (k_q == KW'(PPW - 1)) begin
            k_d      = '0;
            fifo_pop = 1'b1;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
    end

    // In-flight tracker: bit 0 is the read issued this cycle, the top bit
    // marks the cycle its data is on ram_data.
    vld_d[0] = rd_issue;
    for (int i = 1; i < RD_LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
    end

    if (rd_issue) begin
      addr_d = (addr_q == AW'(FRAME_WORDS - 1)) ? '0 : addr_q + AW'(1);
    end

    if (fifo_wr) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (fifo_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({fifo_wr, fifo_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    if ((state_q == FILL) && (count_d == CW'(FIFO_DEPTH))) begin
      state_d = STREAM;
    end

    // Restart overrides everything above except the zero pixel answer.
    if (frame_start) begin
      state_d     = FILL;
      addr_d      = '0;
      vld_d       = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      k_d         = '0;
      underflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      vld_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      k_q           <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      vld_q         <= vld_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      k_q           <= k_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      underflow_q   <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      fifo_mem[wr_ptr_q] <= ram_data;
    end
  end

endmodule
